// File: rtl/nibble_feeder_if.sv
// Host byte handshake and core-side nibble handshake for nibble_feeder.
// The slave modport is the feeder; the master modport is the host/consumer side.
interface nibble_feeder_if #(
  parameter int unsigned DEPTH = 4
);
  logic [7:0]             byte_in;
  logic                   byte_valid;
  logic                   byte_ready;
  logic [3:0]             nib_out;
  logic                   nib_valid;
  logic                   nib_req;
  logic                   underrun;
  logic                   clr_underrun;
  logic [$clog2(DEPTH):0] level;

  modport slave (
    input  byte_in, byte_valid, nib_req, clr_underrun,
    output byte_ready, nib_out, nib_valid, underrun, level
  );

  modport master (
    output byte_in, byte_valid, nib_req, clr_underrun,
    input  byte_ready, nib_out, nib_valid, underrun, level
  );
endinterface

// File: rtl/nibble_feeder.sv
// Byte FIFO feeding the 5401 core's 4-bit data_in bus one nibble per consumer request.
// Full/empty come from the byte level counter; a byte leaves only after its second nibble.
module nibble_feeder #(
  parameter int unsigned DEPTH     = 4,
  parameter bit          LSN_FIRST = 1'b1,
  parameter logic [3:0]  IDLE_NIB  = 4'h0
) (
  input  logic           CLK,
  input  logic           RST,
  nibble_feeder_if.slave bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          phase_q, phase_d;
  logic          underrun_q, underrun_d;

  logic          byte_ready_s;
  logic          nib_valid_s;
  logic          sel_hi_s;
  logic          push_s;
  logic          take_s;
  logic          pop_s;
  logic [7:0]    head_s;

  // Handshake decode and nibble presentation from registered state
  always_comb begin
    byte_ready_s = (level_q != FULL_LVL);
    nib_valid_s  = (level_q != {LW{1'b0}});
    push_s       = bus.byte_valid & byte_ready_s;
    take_s       = bus.nib_req & nib_valid_s;
    pop_s        = take_s & phase_q;
    sel_hi_s     = phase_q ^ ~LSN_FIRST;
    head_s       = mem_q[rd_ptr_q];
  end

  // Next-state for pointers, phase, level and the sticky underrun flag
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    phase_d    = phase_q;
    level_d    = level_q;
    underrun_d = underrun_q;

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (take_s) begin
      phase_d = ~phase_q;
    end else begin
      phase_d = phase_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    // A request against an empty buffer beats a simultaneous clear
    if (bus.nib_req & ~nib_valid_s) begin
      underrun_d = 1'b1;
    end else if (bus.clr_underrun) begin
      underrun_d = 1'b0;
    end else begin
      underrun_d = underrun_q;
    end
  end

  // Control state registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr_q   <= {PW{1'b0}};
      rd_ptr_q   <= {PW{1'b0}};
      level_q    <= {LW{1'b0}};
      phase_q    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      phase_q    <= phase_d;
      underrun_q <= underrun_d;
    end
  end

  // Byte storage; contents are don't-care after reset
  always_ff @(posedge CLK) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= bus.byte_in;
    end
  end

  // Output drive
  always_comb begin
    bus.byte_ready = byte_ready_s;
    bus.nib_valid  = nib_valid_s;
    bus.underrun   = underrun_q;
    bus.level      = level_q;
    if (nib_valid_s) begin
      bus.nib_out = sel_hi_s ? head_s[7:4] : head_s[3:0];
    end else begin
      bus.nib_out = IDLE_NIB;
    end
  end
endmodule

// File: tb/tb_nibble_feeder.sv
// Bench for nibble_feeder: two instances (low-nibble-first and high-nibble-first) share stimulus
// and are checked every cycle against a nibble-queue model plus directed literal expectations.
module tb_nibble_feeder;
  localparam int unsigned DEPTH = 4;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] bi  = 8'h00;
  logic       bv  = 1'b0;
  logic       nr  = 1'b0;
  logic       clr = 1'b0;

  int n_vec  = 0;
  int n_err  = 0;
  bit chk_on = 1'b0;

  // Model: nibbles still to be presented, in presentation order, per instance
  logic [3:0] nq_lsn[$];
  logic [3:0] nq_msn[$];
  logic       m_unr = 1'b0;
  int         m_lvl;
  bit         m_push;
  bit         m_take;

  nibble_feeder_if #(.DEPTH(DEPTH)) bus_lsn ();
  nibble_feeder_if #(.DEPTH(DEPTH)) bus_msn ();

  assign bus_lsn.byte_in      = bi;
  assign bus_lsn.byte_valid   = bv;
  assign bus_lsn.nib_req      = nr;
  assign bus_lsn.clr_underrun = clr;
  assign bus_msn.byte_in      = bi;
  assign bus_msn.byte_valid   = bv;
  assign bus_msn.nib_req      = nr;
  assign bus_msn.clr_underrun = clr;

  nibble_feeder #(.DEPTH(DEPTH), .LSN_FIRST(1'b1), .IDLE_NIB(4'h0)) u_lsn (
    .CLK(CLK), .RST(RST), .bus(bus_lsn)
  );
  nibble_feeder #(.DEPTH(DEPTH), .LSN_FIRST(1'b0), .IDLE_NIB(4'hF)) u_msn (
    .CLK(CLK), .RST(RST), .bus(bus_msn)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int bytes_held();
    return (nq_lsn.size() + 1) / 2;
  endfunction

  // Model update: a byte is two nibbles, a request removes one nibble
  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      nq_lsn.delete();
      nq_msn.delete();
      m_unr <= 1'b0;
    end else begin
      m_lvl  = bytes_held();
      m_push = bv && (m_lvl != DEPTH);
      m_take = nr && (nq_lsn.size() != 0);
      if (nr && nq_lsn.size() == 0) m_unr <= 1'b1;
      else if (clr)                 m_unr <= 1'b0;
      if (m_take) begin
        void'(nq_lsn.pop_front());
        void'(nq_msn.pop_front());
      end
      if (m_push) begin
        nq_lsn.push_back(bi[3:0]);
        nq_lsn.push_back(bi[7:4]);
        nq_msn.push_back(bi[7:4]);
        nq_msn.push_back(bi[3:0]);
      end
    end
  end

  // Per-cycle comparison away from the active edge
  always @(negedge CLK) begin
    if (chk_on) begin
      chk("cmp_level",     32'(bus_lsn.level),      32'(bytes_held()));
      chk("cmp_level_msn", 32'(bus_msn.level),      32'(bytes_held()));
      chk("cmp_ready",     32'(bus_lsn.byte_ready), 32'(bytes_held() != DEPTH));
      chk("cmp_valid",     32'(bus_lsn.nib_valid),  32'(nq_lsn.size() != 0));
      chk("cmp_valid_msn", 32'(bus_msn.nib_valid),  32'(nq_msn.size() != 0));
      chk("cmp_nib_lsn",   32'(bus_lsn.nib_out),    32'((nq_lsn.size() != 0) ? nq_lsn[0] : 4'h0));
      chk("cmp_nib_msn",   32'(bus_msn.nib_out),    32'((nq_msn.size() != 0) ? nq_msn[0] : 4'hF));
      chk("cmp_underrun",  32'(bus_lsn.underrun),   32'(m_unr));
      chk("cmp_unr_msn",   32'(bus_msn.underrun),   32'(m_unr));
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    bv = 1'b1;
    bi = b;
    tick();
    bv = 1'b0;
  endtask

  task automatic req();
    nr = 1'b1;
    tick();
    nr = 1'b0;
  endtask

  logic [3:0] exp_drain [10] = '{4'h1, 4'h0, 4'h3, 4'h2, 4'h5, 4'h4, 4'h7, 4'h6, 4'h9, 4'h8};
  logic [3:0] got_drain [10];

  initial begin
    #2 RST = 1'b0;
    #1;
    chk("rst_ready", 32'(bus_lsn.byte_ready), 32'd1);
    chk("rst_valid", 32'(bus_lsn.nib_valid),  32'd0);
    chk("rst_nib",   32'(bus_lsn.nib_out),    32'h0);
    chk("rst_idle_msn", 32'(bus_msn.nib_out), 32'hF);
    chk("rst_level", 32'(bus_lsn.level),      32'd0);
    chk("rst_unr",   32'(bus_lsn.underrun),   32'd0);
    tick();
    tick();
    RST    = 1'b1;
    chk_on = 1'b1;

    // Single byte A5 (and 3C seen high-nibble-first on the other instance)
    push_byte(8'hA5);
    chk("a5_first",  32'(bus_lsn.nib_out), 32'h5);
    chk("a5_valid",  32'(bus_lsn.nib_valid), 32'd1);
    chk("a5_lvl1",   32'(bus_lsn.level), 32'd1);
    req();
    chk("a5_second", 32'(bus_lsn.nib_out), 32'hA);
    chk("a5_lvl2",   32'(bus_lsn.level), 32'd1);
    req();
    chk("a5_empty",  32'(bus_lsn.nib_valid), 32'd0);
    chk("a5_idle",   32'(bus_lsn.nib_out), 32'h0);
    chk("a5_lvl3",   32'(bus_lsn.level), 32'd0);
    push_byte(8'h3C);
    chk("3c_first_msn",  32'(bus_msn.nib_out), 32'h3);
    req();
    chk("3c_second_msn", 32'(bus_msn.nib_out), 32'hC);
    req();

    // Fill to DEPTH, hold a fifth byte, then drain across pointer wrap
    push_byte(8'h01);
    push_byte(8'h23);
    push_byte(8'h45);
    push_byte(8'h67);
    bv = 1'b1;
    bi = 8'h89;
    tick();
    chk("full_ready", 32'(bus_lsn.byte_ready), 32'd0);
    chk("full_level", 32'(bus_lsn.level), 32'd4);
    for (int i = 0; i < 2; i++) begin
      got_drain[i] = bus_lsn.nib_out;
      req();
    end
    chk("after_pop_level", 32'(bus_lsn.level), 32'd3);
    tick();
    bv = 1'b0;
    chk("accept_89_level", 32'(bus_lsn.level), 32'd4);
    for (int i = 2; i < 10; i++) begin
      got_drain[i] = bus_lsn.nib_out;
      req();
    end
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("drain_%0d", i), 32'(got_drain[i]), 32'(exp_drain[i]));
    end

    // Underrun: set, persist, set beats clear, clear alone
    req();
    chk("unr_set", 32'(bus_lsn.underrun), 32'd1);
    tick();
    chk("unr_hold", 32'(bus_lsn.underrun), 32'd1);
    nr  = 1'b1;
    clr = 1'b1;
    tick();
    nr  = 1'b0;
    chk("unr_set_wins", 32'(bus_lsn.underrun), 32'd1);
    tick();
    clr = 1'b0;
    chk("unr_clear", 32'(bus_lsn.underrun), 32'd0);

    // Steady streaming at level 2
    push_byte(8'h00);
    push_byte(8'h01);
    for (int k = 2; k < 22; k++) begin
      nr = 1'b1;
      tick();
      bv = 1'b1;
      bi = 8'(k);
      tick();
      bv = 1'b0;
      nr = 1'b0;
      chk($sformatf("stream_lvl_%0d", k), 32'(bus_lsn.level), 32'd2);
    end
    repeat (4) req();
    chk("stream_empty", 32'(bus_lsn.nib_valid), 32'd0);

    // Reset mid-operation
    push_byte(8'h11);
    push_byte(8'h22);
    push_byte(8'h33);
    req();
    #2 RST = 1'b0;
    #1;
    chk("midrst_level", 32'(bus_lsn.level), 32'd0);
    chk("midrst_valid", 32'(bus_lsn.nib_valid), 32'd0);
    chk("midrst_ready", 32'(bus_lsn.byte_ready), 32'd1);
    tick();
    RST = 1'b1;
    push_byte(8'hE7);
    chk("e7_first",     32'(bus_lsn.nib_out), 32'h7);
    chk("e7_first_msn", 32'(bus_msn.nib_out), 32'hE);
    req();
    chk("e7_second",    32'(bus_lsn.nib_out), 32'hE);
    req();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
